// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM sequencer: FSM encoding, default derived
// constants and the counter-width helper.
package gemm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_CHUNK = 96 / 16;
  localparam int DEF_CHUNK_CYC = 1 + 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Never let a counter collapse to zero bits when a count of one is requested.
  function automatic int cnt_w(input int value);
    int r;
    r = clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gemm_acc.sv
// One signed accumulator for a PE array column: sign-extends each chunk
// result and adds it on enable; clear wins over enable.
module gemm_acc
  import gemm_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_din_ext;

  assign w_din_ext = ACC_W'(din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_din_ext;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/gemm_ctrl.sv
// Sequencer for the 2-column PE array: steps chunk addresses, holds each one
// until the array output settles, accumulates both columns, hands off on valid/ready.
module gemm_ctrl
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PE_OUT_WIDTH = 24,
  parameter int ARRAY_N      = 16,
  parameter int CHANNEL      = 96,
  parameter int RD_LAT       = 1,
  parameter int GEMM_LAT     = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic        [ADDR_WIDTH-1:0]   base_inp_addr,
  input  logic        [ADDR_WIDTH-1:0]   base_wgt_addr,
  output logic                           busy,
  output logic                           mem_rd_en,
  output logic        [ADDR_WIDTH-1:0]   inp_addr,
  output logic        [ADDR_WIDTH-1:0]   wgt_addr,
  input  logic signed [PE_OUT_WIDTH-1:0] gemm_result1,
  input  logic signed [PE_OUT_WIDTH-1:0] gemm_result2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_WIDTH-1:0]    out_data1,
  output logic signed [ACC_WIDTH-1:0]    out_data2
);

  localparam int NUM_CHUNK = CHANNEL / ARRAY_N;
  localparam int CHUNK_CYC = RD_LAT + GEMM_LAT;
  localparam int CHUNK_W   = cnt_w(NUM_CHUNK);
  localparam int HOLD_W    = cnt_w(CHUNK_CYC);

  localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(NUM_CHUNK - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(CHUNK_CYC - 1);

  if (CHANNEL % ARRAY_N != 0) begin : g_chk_channel
    $error("CHANNEL must be a multiple of ARRAY_N");
  end
  if (ACC_WIDTH < PE_OUT_WIDTH) begin : g_chk_acc
    $error("ACC_WIDTH must be at least PE_OUT_WIDTH");
  end
  if (PE_OUT_WIDTH < 2 * DATA_WIDTH) begin : g_chk_pe
    $error("PE_OUT_WIDTH too narrow for DATA_WIDTH products");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_acc_clr;
  logic                    w_acc_en;
  logic                    w_chunk_end;
  logic [CHUNK_W-1:0]      r_chunk_cnt;
  logic [CHUNK_W-1:0]      w_chunk_inc;
  logic [HOLD_W-1:0]       r_hold_cnt;
  logic [ADDR_WIDTH-1:0]   r_base_inp;
  logic [ADDR_WIDTH-1:0]   r_base_wgt;
  logic [ADDR_WIDTH-1:0]   r_inp_addr;
  logic [ADDR_WIDTH-1:0]   r_wgt_addr;
  logic                    r_busy;
  logic                    r_mem_rd_en;
  logic                    r_out_valid;

  assign w_chunk_inc = r_chunk_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;
    w_chunk_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_acc_clr   = 1'b1;
        end
      end
      RUN: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_chunk_end = 1'b1;
          w_acc_en    = 1'b1;
          if (r_chunk_cnt == CHUNK_LAST) w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chunk_cnt <= '0;
      r_hold_cnt  <= '0;
      r_base_inp  <= '0;
      r_base_wgt  <= '0;
      r_inp_addr  <= '0;
      r_wgt_addr  <= '0;
      r_busy      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != IDLE);
      r_mem_rd_en <= (w_state_nxt == RUN);
      r_out_valid <= (w_state_nxt == DONE);
      if (r_state == IDLE && start) begin
        r_base_inp  <= base_inp_addr;
        r_base_wgt  <= base_wgt_addr;
        r_inp_addr  <= base_inp_addr;
        r_wgt_addr  <= base_wgt_addr;
        r_chunk_cnt <= '0;
        r_hold_cnt  <= '0;
      end else if (r_state == RUN) begin
        if (w_chunk_end) begin
          r_hold_cnt  <= '0;
          r_chunk_cnt <= w_chunk_inc;
          if (r_chunk_cnt != CHUNK_LAST) begin
            r_inp_addr <= r_base_inp + ADDR_WIDTH'(w_chunk_inc);
            r_wgt_addr <= r_base_wgt + ADDR_WIDTH'(w_chunk_inc);
          end
        end else begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  gemm_acc #(
    .IN_W  (PE_OUT_WIDTH),
    .ACC_W (ACC_WIDTH)
  ) u_acc1 (
    .clk (clk),
    .rst (rst),
    .clr (w_acc_clr),
    .en  (w_acc_en),
    .din (gemm_result1),
    .acc (out_data1)
  );

  gemm_acc #(
    .IN_W  (PE_OUT_WIDTH),
    .ACC_W (ACC_WIDTH)
  ) u_acc2 (
    .clk (clk),
    .rst (rst),
    .clr (w_acc_clr),
    .en  (w_acc_en),
    .din (gemm_result2),
    .acc (out_data2)
  );

  assign busy      = r_busy;
  assign mem_rd_en = r_mem_rd_en;
  assign inp_addr  = r_inp_addr;
  assign wgt_addr  = r_wgt_addr;
  assign out_valid = r_out_valid;

endmodule
